// File: rtl/clk_div_sched_if.sv
// Configuration, control and status bundle for the scheduled clock divider.
interface clk_div_sched_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic [7:0]       cfg_burst;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic             out_clk;
  logic             tick;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, out_clk, tick, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, out_clk, tick, busy, done
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock divider with burst count, graceful stop and a one-deep
// shadow register so settings only change on a period boundary.
module clk_div_sched #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_sched_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic             out_clk_q, out_clk_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [7:0]       act_burst_q, act_burst_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic [7:0]       sh_burst_q, sh_burst_d;
  logic             sh_full_q, sh_full_d;

  logic             accept;
  logic [CNT_W-1:0] cfg_div_n;
  logic             phase_end;
  logic             boundary;
  logic             burst_end;

  assign accept    = bus.cfg_valid && !sh_full_q;
  assign cfg_div_n = (bus.cfg_div == '0) ? CNT_W'(1) : bus.cfg_div;
  assign phase_end = (hcnt_q == act_div_q - CNT_W'(1));
  assign boundary  = (state_q == RUN) && !out_clk_q && phase_end;
  assign burst_end = (act_burst_q != 8'd0) && (pcnt_q == act_burst_q);

  always_comb begin
    state_d     = state_q;
    out_clk_d   = out_clk_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    act_div_d   = act_div_q;
    act_burst_d = act_burst_q;
    sh_div_d    = sh_div_q;
    sh_burst_d  = sh_burst_q;
    sh_full_d   = sh_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          act_div_d   = cfg_div_n;
          act_burst_d = bus.cfg_burst;
        end
        if (bus.start) begin
          state_d     = RUN;
          out_clk_d   = 1'b1;
          tick_d      = 1'b1;
          hcnt_d      = '0;
          pcnt_d      = 8'd1;
          stop_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (accept) begin
          sh_div_d   = cfg_div_n;
          sh_burst_d = bus.cfg_burst;
          sh_full_d  = 1'b1;
        end
        if (boundary) begin
          hcnt_d = '0;
          if (sh_full_q) begin
            act_div_d   = sh_div_q;
            act_burst_d = sh_burst_q;
            sh_full_d   = 1'b0;
          end
          if (burst_end || stop_pend_q) begin
            state_d     = IDLE;
            out_clk_d   = 1'b0;
            done_d      = burst_end;
            stop_pend_d = 1'b0;
            pcnt_d      = 8'd0;
            // A setting accepted on the way out would otherwise strand in the shadow.
            if (accept) begin
              act_div_d   = cfg_div_n;
              act_burst_d = bus.cfg_burst;
              sh_full_d   = 1'b0;
            end
          end else begin
            out_clk_d = 1'b1;
            tick_d    = 1'b1;
            pcnt_d    = (pcnt_q == 8'hff) ? pcnt_q : pcnt_q + 8'd1;
          end
        end else if (phase_end) begin
          out_clk_d = 1'b0;
          hcnt_d    = '0;
        end else begin
          hcnt_d = hcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_clk_q   <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      hcnt_q      <= '0;
      pcnt_q      <= 8'd0;
      act_div_q   <= CNT_W'(DEF_DIV);
      act_burst_q <= 8'd0;
      sh_div_q    <= '0;
      sh_burst_q  <= 8'd0;
      sh_full_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_clk_q   <= out_clk_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      act_div_q   <= act_div_d;
      act_burst_q <= act_burst_d;
      sh_div_q    <= sh_div_d;
      sh_burst_q  <= sh_burst_d;
      sh_full_q   <= sh_full_d;
    end
  end

  assign bus.cfg_ready = !sh_full_q;
  assign bus.out_clk   = out_clk_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed checks of the scheduled clock divider; outputs sampled 1ns after the edge.
module tb_clk_div_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clk_div_sched_if #(.CNT_W(8)) bus();

  clk_div_sched #(.CNT_W(8), .DEF_DIV(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // obs = {out_clk, tick, busy, done, cfg_ready}
  logic [4:0] obs, exp_v;
  assign obs = {bus.out_clk, bus.tick, bus.busy, bus.done, bus.cfg_ready};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] div, input logic [7:0] burst);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = div;
    bus.cfg_burst = burst;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== 5'b00001) begin
        errors++;
        $display("FAIL reset cyc %0d got %b want %b", i, obs, 5'b00001);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_default();
    // idle cycles 1..9, start sampled in cycle 10
    for (int i = 1; i < 10; i++) begin
      step();
      checks++;
      if (obs !== 5'b00001) begin
        errors++;
        $display("FAIL default_idle cyc %0d got %b want %b", i, obs, 5'b00001);
      end
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 42; i++) begin
      bus.stop = (i == 30);
      exp_v = {(i < 40) && (i % 10 < 5), (i < 40) && (i % 10 == 0), i < 40, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL default cyc %0d got %b want %b", i + 11, obs, exp_v);
      end
      step();
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_burst();
    set_cfg(8'd2, 8'd3);
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL burst_cfg_idle got %b want %b", obs, 5'b00001);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {(i < 12) && (i % 4 < 2), (i < 12) && (i % 4 == 0), i < 12, i == 12, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL burst cyc %0d got %b want %b", i, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_shadow();
    logic [0:23] e_out, e_tick, e_rdy;
    e_out  = 24'b1111_0000_1010_1010_1110_0011;
    e_tick = 24'b1000_0000_1010_1010_1000_0010;
    e_rdy  = 24'b1100_0000_1111_1010_1111_1111;
    set_cfg(8'd4, 8'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      case (i)
        1:  begin bus.cfg_valid = 1'b1; bus.cfg_div = 8'd1; bus.cfg_burst = 8'd0; end
        2:  bus.cfg_valid = 1'b0;
        12: begin bus.cfg_valid = 1'b1; bus.cfg_div = 8'd0; end
        13: begin bus.cfg_valid = 1'b1; bus.cfg_div = 8'd3; end
        15: bus.cfg_valid = 1'b0;
        default: ;
      endcase
      exp_v = {e_out[i], e_tick[i], 1'b1, 1'b0, e_rdy[i]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL shadow cyc %0d got %b want %b", i, obs, exp_v);
      end
      step();
    end
    bus.cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_stop();
    logic [0:20] e_out, e_tick, e_busy;
    e_out  = 21'b1110_0001_1100_0111_0000_0;
    e_tick = 21'b1000_0001_0000_0100_0000_0;
    e_busy = 21'b1111_1101_1111_1111_1110_0;
    set_cfg(8'd3, 8'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 21; i++) begin
      bus.stop  = (i == 1) || (i == 14);
      bus.start = (i == 6) || (i == 14);
      exp_v = {e_out[i], e_tick[i], e_busy[i], 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stop cyc %0d got %b want %b", i, obs, exp_v);
      end
      step();
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_burst_stop();
    logic [0:5] e_out, e_tick, e_busy, e_done;
    e_out  = 6'b1010_00;
    e_tick = 6'b1010_00;
    e_busy = 6'b1111_00;
    e_done = 6'b0000_10;
    set_cfg(8'd1, 8'd2);
    // start and stop together in IDLE: start wins, stop is dropped
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.stop = (i == 2);
      exp_v = {e_out[i], e_tick[i], e_busy[i], e_done[i], 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL burst_stop cyc %0d got %b want %b", i, obs, exp_v);
      end
      step();
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_rst_run();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    set_cfg(8'd2, 8'd0);
    checks++;
    if (obs !== 5'b10100) begin
      errors++;
      $display("FAIL rst_run_shadow got %b want %b", obs, 5'b10100);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL rst_run_abort got %b want %b", obs, 5'b00001);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_v = {i % 10 < 5, i % 10 == 0, 1'b1, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rst_run_restart cyc %0d got %b want %b", i, obs, exp_v);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = 8'd0;
    bus.cfg_burst = 8'd0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    test_reset();
    test_default();
    test_burst();
    test_shadow();
    test_stop();
    test_burst_stop();
    test_rst_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 Parameter CNT_W, default 8: width of the half-period count and of cfg_div.
REQ-002 Parameter DEF_DIV, default 5: half-period length in clk cycles that is loaded at reset.
REQ-003 clk  input  1: single clock; all logic on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 cfg_valid  input  1: a new divide setting is offered.
REQ-006 cfg_div  input  CNT_W: new half-period length in clk cycles; 0 is treated as 1.
REQ-007 cfg_burst  input  8: number of out_clk periods to emit; 0 means continuous.
REQ-008 cfg_ready  output  1: the shadow register is empty and can accept a setting.
REQ-009 start  input  1: single-cycle request to begin generation.
REQ-010 stop  input  1: single-cycle request to end generation at the next period boundary.
REQ-011 out_clk  output  1: generated divided clock, registered.
REQ-012 tick  output  1: one-cycle pulse in each cycle in which out_clk goes from 0 to 1.
REQ-013 busy  output  1: high while the state is RUN.
REQ-014 done  output  1: one-cycle pulse when a burst completes.

Function
REQ-015 States: IDLE and RUN; the active settings are act_div and act_burst; the shadow settings are sh_div and sh_burst, qualified by sh_full; the counters are hcnt (CNT_W bits) and pcnt (8 bits).
REQ-016 Handshake: a setting transfers when cfg_valid and cfg_ready are both 1; cfg_ready = !sh_full.
REQ-017 In IDLE, an accepted setting is written directly into act_* on the next cycle, and sh_full stays 0.
REQ-018 In RUN, an accepted setting is written into sh_* and sh_full is set.
REQ-019 Shadow settings move to act_* only at a period boundary; sh_full then clears, and cfg_ready returns to 1 on the following cycle.
REQ-020 Start: start in IDLE in cycle N gives state RUN, out_clk=1, tick=1, hcnt=0 and pcnt=1 in cycle N+1.
REQ-021 start while in RUN is ignored.
REQ-022 High phase: out_clk stays 1 for act_div cycles, with hcnt counting 0..act_div-1.
REQ-023 Low phase: out_clk stays 0 for act_div cycles, so one period is 2*act_div cycles.
REQ-024 Period boundary: the last cycle of a low phase (hcnt = act_div-1 with out_clk = 0).
REQ-025 At a boundary with no stop and no burst completion, the next cycle has out_clk=1, tick=1, hcnt=0 and pcnt+1, using any shadow setting just applied.
REQ-026 Burst completion: act_burst != 0 and pcnt = act_burst at a boundary gives state IDLE, out_clk=0 and done=1 in the next cycle.
REQ-027 Stop: stop in RUN sets stop_pend; at the next boundary the state goes to IDLE with done=0, and stop_pend clears.
REQ-028 stop while in IDLE is ignored.
REQ-029 start and stop in the same cycle: in IDLE, start is honoured; in RUN, stop is honoured.
REQ-030 Simultaneous burst completion and stop_pend produce done=1.
REQ-031 A shadow setting pending when the block enters IDLE is applied on that same transition.
REQ-032 act_div = 1 gives out_clk toggling every cycle, with a period of 2 cycles.
REQ-033 pcnt saturates at 255 when act_burst = 0.
REQ-034 In IDLE, out_clk = 0, tick = 0 and busy = 0.

Reset
REQ-035 While rst is 1 at a clock edge, the next cycle has: state IDLE, out_clk=0, tick=0, done=0, busy=0, act_div=DEF_DIV, act_burst=0, sh_full=0, cfg_ready=1, hcnt=0, pcnt=0 and stop_pend=0.
REQ-036 rst asserted during RUN aborts immediately: no done pulse, and any pending setting is discarded.

Verification
REQ-037 Reset, then start at cycle 10 with defaults: out_clk high in cycles 11-15 and low in cycles 16-20, with tick at 11, 21, 31 and so on; continuous output.
REQ-038 In IDLE, cfg_div=2 and cfg_burst=3, then start: exactly 3 periods of 4 cycles; done=1 in the cycle after the 3rd low phase; busy falls at the same time; out_clk then stays 0.
REQ-039 In RUN with act_div=4, cfg_div=1 is accepted mid-high-phase: the current period completes at 8 cycles; cfg_ready is 0 until the boundary; subsequent periods are 2 cycles.
REQ-040 stop mid-high-phase with act_div=3: the low phase completes (3 cycles), then IDLE; no done pulse; a start one cycle later restarts cleanly.
REQ-041 cfg_div=0 is accepted and treated as 1; a second cfg_valid while sh_full=1 is held off (cfg_ready=0) until the boundary.
REQ-042 rst asserted during RUN with sh_full=1: the next cycle has out_clk=0, cfg_ready=1 and act_div=DEF_DIV.
